rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters (switch/device channels) using a rotating-priority 8->3 encode.
- Registers a one-hot grant plus a 3-bit grant index and a valid flag.
- The grant is held until the holder drops its request. No preemption.
- Sits between the request sources and the shared datapath. Downstream logic muxes on gnt_id when gnt_valid=1.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_arbiter_8.sv | 157 +++++++++++++++
 tb/tb_rr_arbiter_8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after a bounded hold).
package arb_pkg;

  localparam int unsigned N               = 8;
  localparam int unsigned IDW             = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNTW            = IDW + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [N-1:0]   req_t;
  typedef logic [IDW-1:0] id_t;

  // One-hot vector with bit `id` set.
  function automatic req_t onehot(input id_t id);
    return req_t'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encode: first eligible requester searching downward from
// ptr with wrap (ptr, ptr-1, ..., 0, N-1, ..., ptr+1).
// Ports:
//   req       request vector
//   mask      requesters excluded from this search
//   ptr       highest-priority index for this search
//   win_id    winning index (valid only with win_valid)
//   win_valid at least one eligible requester exists
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win_id,
  output logic           win_valid
);

  req_t elig;
  req_t rot;
  id_t  sel;

  // rot[N-1] is ptr itself, rot[0] is ptr+1, so highest-index-first on rot
  // is exactly the descending search from ptr.
  always_comb begin
    elig      = req & ~mask;
    rot       = '0;
    sel       = '0;
    win_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      rot[j] = elig[ptr + id_t'(j + 1)];
    end
    for (int j = 0; j < N; j++) begin
      if (rot[j]) begin
        sel       = id_t'(j);
        win_valid = 1'b1;
      end
    end
    win_id = ptr + id_t'(1) + sel;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, grant held until the holder drops req.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter, a forced
// release after TIMEOUT cycles and the timeout pulse output.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          allow new grants (never revokes an active one)
//   req         request vector
//   gnt         one-hot grant (registered)
//   gnt_id      grant index, keeps last value when idle (registered)
//   gnt_valid   grant active (registered)
//   timeout     one-cycle pulse on forced release (ARB_TIMEOUT_EN only)
module rr_arbiter_8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
`endif
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic           timeout
`endif
);

  state_t state_q, state_d;
  id_t    ptr_q, ptr_d;
  req_t   gnt_d;
  id_t    gnt_id_d;
  logic   gnt_valid_d;
  req_t   pick_mask;
  req_t   blk_mask;
  id_t    win_id;
  logic   win_valid;
  logic   keep;
  logic   new_grant;

`ifdef ARB_TIMEOUT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            blk_valid_q, blk_valid_d;
  id_t             blk_id_q, blk_id_d;
  logic            timeout_d;
  logic            force_rel;

  assign force_rel = (state_q == GRANT) && req[gnt_id] &&
                     (cnt_q == CNTW'(TIMEOUT - 1));
  assign blk_mask  = blk_valid_q ? onehot(blk_id_q) : '0;
  assign keep      = req[gnt_id] && !force_rel;
`else
  assign blk_mask  = '0;
  assign keep      = req[gnt_id];
`endif

  // The holder is always excluded; its bit only matters on a release search.
  assign pick_mask = blk_mask | ((state_q == GRANT) ? onehot(gnt_id) : '0);

  rr_pick u_pick (
    .req       (req),
    .mask      (pick_mask),
    .ptr       (ptr_q),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    new_grant   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    blk_valid_d = blk_valid_q && req[blk_id_q];
    blk_id_d    = blk_id_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (en && win_valid) new_grant = 1'b1;
      end
      GRANT: begin
        if (keep) begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNTW'(1);
`endif
        end else if (en && win_valid) begin
          new_grant = 1'b1;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_grant) begin
      state_d     = GRANT;
      gnt_d       = onehot(win_id);
      gnt_id_d    = win_id;
      gnt_valid_d = 1'b1;
      ptr_d       = win_id - id_t'(1);
`ifdef ARB_TIMEOUT_EN
      cnt_d       = '0;
`endif
    end

`ifdef ARB_TIMEOUT_EN
    // Forced-out holder stays masked until it drops req for a cycle.
    if (force_rel) begin
      timeout_d   = 1'b1;
      blk_valid_d = 1'b1;
      blk_id_d    = gnt_id;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= id_t'(N - 1);
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_id_q    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      blk_valid_q <= blk_valid_d;
      blk_id_q    <= blk_id_d;
      timeout     <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random
// request traffic against a behavioural round-robin model.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  rr_arbiter_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  int m_ptr, m_id, m_cnt, m_blk_id;
  bit m_busy, m_blk, m_to;

  function automatic int search(input logic [7:0] r, input logic [7:0] msk, input int p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p - k + 8) % 8;
      if (r[i] && !msk[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 7; m_id = 0; m_cnt = 0; m_busy = 0; m_blk = 0; m_blk_id = 0; m_to = 0;
  endtask

  task automatic model_clock();
    logic [7:0] msk;
    int w;
    bit newg, forced;
    msk = 8'h00; newg = 0; forced = 0; m_to = 0; w = -1;
    if (m_blk) msk[m_blk_id] = 1'b1;
    if (!m_busy) begin
      w = search(req, msk, m_ptr);
      newg = en && (w >= 0);
    end else begin
      forced = TO_EN && req[m_id] && (m_cnt == 15);
      if (req[m_id] && !forced) begin
        m_cnt++;
      end else begin
        msk[m_id] = 1'b1;
        w = search(req, msk, m_ptr);
        newg = en && (w >= 0);
        if (!newg) m_busy = 0;
      end
    end
    if (m_blk && !req[m_blk_id]) m_blk = 0;
    if (forced) begin m_to = 1; m_blk = 1; m_blk_id = m_id; end
    if (newg) begin
      m_busy = 1; m_id = w; m_ptr = (w + 7) % 8; m_cnt = 0;
    end
  endtask

  // One clock: advance the model, then compare all outputs after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check({tag, "_gnt"}, 32'(gnt), m_busy ? (32'd1 << m_id) : 32'd0);
    check({tag, "_id"}, 32'(gnt_id), 32'(m_id));
    check({tag, "_valid"}, 32'(gnt_valid), 32'(m_busy));
`ifdef ARB_TIMEOUT_EN
    check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    model_reset();
    #12;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_id", 32'(gnt_id), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First grant and hold with no gap on handover
    req = 8'h81; en = 1'b1;
    step("first");
    check("first_gnt80", 32'(gnt), 32'h80);
    check("first_id7", 32'(gnt_id), 32'd7);
    for (int k = 0; k < 5; k++) step("hold81");
    check("hold_gnt80", 32'(gnt), 32'h80);
    req = 8'h01;
    step("handover");
    check("handover_gnt01", 32'(gnt), 32'h01);
    check("handover_valid", 32'(gnt_valid), 32'h1);

    // Full rotation with all requesting
    do_reset();
    req = 8'hFF;
    step("rot0");
    check("rot_id_0", 32'(gnt_id), 32'd7);
    for (int k = 1; k < 9; k++) begin
      req = 8'hFF & ~(8'h01 << gnt_id);
      step("rot");
      check($sformatf("rot_id_%0d", k), 32'(gnt_id), 32'((15 - k) % 8));
      req = 8'hFF;
    end

    // en low blocks new grants but does not revoke
    do_reset();
    req = 8'h08; en = 1'b1;
    step("en_grant");
    en = 1'b0;
    step("en_hold");
    step("en_hold");
    check("en_hold_gnt", 32'(gnt), 32'h08);
    req = 8'h10;
    step("en_drop");
    check("en_drop_valid", 32'(gnt_valid), 32'h0);
    check("en_drop_id", 32'(gnt_id), 32'd3);
    step("en_idle");
    step("en_idle");
    en = 1'b1;
    step("en_resume");
    check("en_resume_id", 32'(gnt_id), 32'd4);

    // Asynchronous reset in the middle of a grant
    req = 8'h10;
    step("pre_arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_valid", 32'(gnt_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF;
    step("post_arst");
    check("post_arst_id", 32'(gnt_id), 32'd7);

`ifdef ARB_TIMEOUT_EN
    // Forced release after 16 hold cycles, blocked until req[2] drops
    do_reset();
    req = 8'h04;
    step("to_grant");
    req = 8'h24;
    for (int k = 1; k < 16; k++) step("to_hold");
    check("to_hold_gnt", 32'(gnt), 32'h04);
    step("to_fire");
    check("to_fire_pulse", 32'(timeout), 32'h1);
    check("to_fire_id", 32'(gnt_id), 32'd5);
    step("to_after");
    req = 8'h04;
    step("to_blocked");
    check("to_blocked_valid", 32'(gnt_valid), 32'h0);
    step("to_blocked");
    req = 8'h00;
    step("to_unblock");
    req = 8'h04;
    step("to_regrant");
    check("to_regrant_id", 32'(gnt_id), 32'd2);
`endif

    // Random traffic: fast-changing, then slow-changing requests
    do_reset();
    r = 8'h00;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 900; c++) begin
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, (ph == 0) ? 5 : 40) == 0) r[b] = ~r[b];
        req = r;
        en  = ($urandom_range(0, 9) != 0);
        step("rand");
        check("rand_onehot", 32'($countones(gnt) <= 1), 32'h1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
